// File: rtl/mult_div_issue_queue.sv
// Issue queue for one multiply or divide unit: an age-ordered compacting buffer that snoops
// the CDB for pending operands and hands the oldest ready entry to the execution unit.
package mult_div_pkg;
  typedef struct packed {
    logic [31:0] rs1_data;
    logic [5:0]  rs1_tag;
    logic        rs1_valid;
    logic [31:0] rs2_data;
    logic [5:0]  rs2_tag;
    logic        rs2_valid;
    logic [5:0]  rd_tag;
  } queue_data;
endpackage

module mult_div_issue_queue
  import mult_div_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_dispatch,
  input  queue_data   dispatch_pkt,
  output logic        queue_full,
  input  logic        flush,
  input  logic        cdb_valid,
  input  logic [5:0]  cdb_tag,
  input  logic [31:0] cdb_data,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [31:0] issue_rs1_data,
  output logic [31:0] issue_rs2_data,
  output logic [5:0]  issue_rd_tag
);

  queue_data              entries_q [DEPTH];
  queue_data              entries_d [DEPTH];
  queue_data              woken     [DEPTH];
  queue_data              incoming;
  logic      [DEPTH-1:0]  busy_q, busy_d;
  logic      [DEPTH-1:0]  shift;
  logic      [CNT_W-1:0]  count_q, count_d, wr_idx;
  logic                   accept, fire, found;

  function automatic queue_data wake(queue_data e, logic cv, logic [5:0] ct, logic [31:0] cd);
    queue_data r;
    r = e;
    if (cv && !e.rs1_valid && e.rs1_tag == ct) begin
      r.rs1_data  = cd;
      r.rs1_valid = 1'b1;
    end
    if (cv && !e.rs2_valid && e.rs2_tag == ct) begin
      r.rs2_data  = cd;
      r.rs2_valid = 1'b1;
    end
    return r;
  endfunction

  // Select works on registered state only, so a CDB wakeup is visible one cycle later.
  always_comb begin
    found          = 1'b0;
    issue_rs1_data = '0;
    issue_rs2_data = '0;
    issue_rd_tag   = '0;
    shift          = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!found && busy_q[i] && entries_q[i].rs1_valid && entries_q[i].rs2_valid) begin
        found          = 1'b1;
        issue_rs1_data = entries_q[i].rs1_data;
        issue_rs2_data = entries_q[i].rs2_data;
        issue_rd_tag   = entries_q[i].rd_tag;
      end
      shift[i] = found;
    end
  end

  assign issue_valid = found;
  assign fire        = found & issue_ready;
  assign queue_full  = (count_q == CNT_W'(DEPTH));
  assign accept      = en_dispatch & ~queue_full;
  assign wr_idx      = count_q - CNT_W'(fire);

  always_comb begin
    incoming = wake(dispatch_pkt, cdb_valid, cdb_tag, cdb_data);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      woken[i] = wake(entries_q[i], cdb_valid, cdb_tag, cdb_data);
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entries_d[i] = woken[i];
      busy_d[i]    = busy_q[i];
      // Slots at and above the issued one take their younger neighbour.
      if (fire && shift[i]) begin
        if (i < DEPTH - 1) begin
          entries_d[i] = woken[(i + 1) % DEPTH];
          busy_d[i]    = busy_q[(i + 1) % DEPTH];
        end else begin
          busy_d[i] = 1'b0;
        end
      end
      if (accept && wr_idx == CNT_W'(i)) begin
        entries_d[i] = incoming;
        busy_d[i]    = 1'b1;
      end
    end
    count_d = count_q + CNT_W'(accept) - CNT_W'(fire);
    if (flush) begin
      busy_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mult_div_issue_queue.sv
// Directed bench for mult_div_issue_queue: expected issues go into a scoreboard queue and a
// negedge monitor checks every accepted issue against it in order.
module tb_mult_div_issue_queue;
  import mult_div_pkg::*;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [5:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_dispatch;
  queue_data   dispatch_pkt;
  logic        queue_full;
  logic        flush;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_rs1_data;
  logic [31:0] issue_rs2_data;
  logic [5:0]  issue_rd_tag;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  mult_div_issue_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_dispatch    (en_dispatch),
    .dispatch_pkt   (dispatch_pkt),
    .queue_full     (queue_full),
    .flush          (flush),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_rs1_data (issue_rs1_data),
    .issue_rs2_data (issue_rs2_data),
    .issue_rd_tag   (issue_rd_tag)
  );

  always #5 clk = ~clk;

  function automatic queue_data mk(logic [31:0] r1, logic v1, logic [5:0] t1,
                                   logic [31:0] r2, logic v2, logic [5:0] t2, logic [5:0] rd);
    queue_data p;
    p.rs1_data = r1; p.rs1_valid = v1; p.rs1_tag = t1;
    p.rs2_data = r2; p.rs2_valid = v2; p.rs2_tag = t2;
    p.rd_tag   = rd;
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] r1, input logic [31:0] r2, input logic [5:0] rd);
    exp_t e;
    e.rs1 = r1; e.rs2 = r2; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input queue_data p);
    en_dispatch  = 1'b1;
    dispatch_pkt = p;
    tick();
    en_dispatch  = 1'b0;
  endtask

  // Monitor: every accepted issue must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && issue_valid && issue_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected: got rd_tag %0d, expected no issue", issue_rd_tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (issue_rs1_data !== e.rs1 || issue_rs2_data !== e.rs2 || issue_rd_tag !== e.rd) begin
          bad++;
          $display("FAIL issue_data: got rs1=0x%0h rs2=0x%0h rd=%0d, expected rs1=0x%0h rs2=0x%0h rd=%0d",
                   issue_rs1_data, issue_rs2_data, issue_rd_tag, e.rs1, e.rs2, e.rd);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; en_dispatch = 1'b0; dispatch_pkt = '0; flush = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;
    tick(); tick();
    check("reset_issue_valid", 32'(issue_valid), 32'd0);
    check("reset_queue_full", 32'(queue_full), 32'd0);
    check("reset_rs1", issue_rs1_data, 32'd0);
    check("reset_rd", 32'(issue_rd_tag), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: ready packet issues the cycle after dispatch
    issue_ready = 1'b1;
    push(32'd5, 32'd7, 6'd3);
    dispatch(mk(32'd5, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 6'd3));
    check("t1_valid", 32'(issue_valid), 32'd1);
    check("t1_rs1", issue_rs1_data, 32'd5);
    tick();
    check("t1_empty", 32'(issue_valid), 32'd0);

    // 2: CDB wakeup becomes issuable the following cycle
    dispatch(mk(32'd0, 1'b0, 6'd9, 32'd2, 1'b1, 6'd0, 6'd4));
    check("t2_wait", 32'(issue_valid), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'hAB;
    #1;
    check("t2_not_same_cycle", 32'(issue_valid), 32'd0);
    push(32'hAB, 32'd2, 6'd4);
    tick();
    cdb_valid = 1'b0;
    check("t2_woken", 32'(issue_valid), 32'd1);
    check("t2_rs1", issue_rs1_data, 32'hAB);
    tick();
    check("t2_empty", 32'(issue_valid), 32'd0);

    // 3: fill, reject when full (also with a same-cycle issue), drain in order
    issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t3_not_full", 32'(queue_full), 32'd0);
      dispatch(mk(32'(10 + k), 1'b1, 6'd0, 32'(20 + k), 1'b1, 6'd0, 6'(10 + k)));
    end
    check("t3_full", 32'(queue_full), 32'd1);
    dispatch(mk(32'd99, 1'b1, 6'd0, 32'd99, 1'b1, 6'd0, 6'd63));
    check("t3_still_full", 32'(queue_full), 32'd1);
    for (int k = 0; k < 4; k++) push(32'(10 + k), 32'(20 + k), 6'(10 + k));
    issue_ready = 1'b1;
    dispatch(mk(32'd77, 1'b1, 6'd0, 32'd77, 1'b1, 6'd0, 6'd62));
    check("t3_after_full_issue", 32'(queue_full), 32'd0);
    repeat (4) tick();
    check("t3_drained", 32'(issue_valid), 32'd0);

    // 4: younger ready entry bypasses a waiting older one; order preserved afterwards
    issue_ready = 1'b0;
    dispatch(mk(32'd0, 1'b0, 6'd2, 32'h30, 1'b1, 6'd0, 6'd20));
    dispatch(mk(32'h41, 1'b1, 6'd0, 32'h42, 1'b1, 6'd0, 6'd21));
    dispatch(mk(32'h51, 1'b1, 6'd0, 32'h52, 1'b1, 6'd0, 6'd22));
    check("t4_first_rd", 32'(issue_rd_tag), 32'd21);
    push(32'h41, 32'h42, 6'd21);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("t4_second_rd", 32'(issue_rd_tag), 32'd22);
    cdb_valid = 1'b1; cdb_tag = 6'd2; cdb_data = 32'h2A;
    tick();
    cdb_valid = 1'b0;
    check("t4_oldest_rd", 32'(issue_rd_tag), 32'd20);
    check("t4_oldest_rs1", issue_rs1_data, 32'h2A);
    push(32'h2A, 32'h30, 6'd20);
    push(32'h51, 32'h52, 6'd22);
    issue_ready = 1'b1;
    tick(); tick();
    issue_ready = 1'b0;
    check("t4_empty", 32'(issue_valid), 32'd0);

    // 5: dispatch bypass from a same-cycle CDB broadcast
    cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_data = 32'h11;
    dispatch(mk(32'd5, 1'b1, 6'd0, 32'd0, 1'b0, 6'd4, 6'd30));
    cdb_valid = 1'b0;
    check("t5_valid", 32'(issue_valid), 32'd1);
    check("t5_rs2", issue_rs2_data, 32'h11);
    push(32'd5, 32'h11, 6'd30);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("t5_empty", 32'(issue_valid), 32'd0);

    // 6: flush beats a same-cycle dispatch, then async reset between edges
    for (int k = 0; k < 3; k++) dispatch(mk(32'(k), 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 6'(40 + k)));
    check("t6_loaded", 32'(issue_valid), 32'd1);
    flush = 1'b1;
    dispatch(mk(32'd1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 6'd50));
    flush = 1'b0;
    check("t6_flush_valid", 32'(issue_valid), 32'd0);
    for (int k = 0; k < 3; k++) dispatch(mk(32'd0, 1'b0, 6'd60, 32'd0, 1'b1, 6'd0, 6'd0));
    check("t6_count_cleared", 32'(queue_full), 32'd0);
    dispatch(mk(32'd0, 1'b0, 6'd60, 32'd0, 1'b1, 6'd0, 6'd0));
    check("t6_refilled_full", 32'(queue_full), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_full", 32'(queue_full), 32'd0);
    rst_n = 1'b1;
    push(32'd8, 32'd9, 6'd33);
    issue_ready = 1'b1;
    dispatch(mk(32'd8, 1'b1, 6'd0, 32'd9, 1'b1, 6'd0, 6'd33));
    check("t6_post_reset_rd", 32'(issue_rd_tag), 32'd33);
    tick();
    issue_ready = 1'b0;
    check("t6_post_reset_empty", 32'(issue_valid), 32'd0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
